// File: rtl/edge_threshold_stats.sv
// edge_threshold_stats
//   Back end of the Sobel edge path. Thresholds the 12-bit edge magnitude
//   into a binary edge map (0x000 / 0xFFF, one cycle of latency). It also
//   gathers per-frame edge statistics (saturating edge count and bounding
//   box) and publishes them when a frame completes.
//
// Ports
//   iCLK, iRST        pixel clock, asynchronous active-low reset
//   iEdge, iDVAL      edge magnitude and its per-pixel valid
//   iFVAL             frame valid, high across the active frame
//   iThreshold        edge threshold, captured at frame start
//   oBin, oDVAL       binary edge map and its valid (iDVAL delayed 1 cycle)
//   oEdgeCount        edge pixels in the last completed frame
//   oMinX..oMaxY      bounding box of those edge pixels
//   oBoxValid         last completed frame had at least one edge pixel
//   oFrameDone        one-cycle pulse, coincident with the statistics update
module edge_threshold_stats #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int BORDER   = 2,
  parameter int CNT_W    = 20
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic [11:0]      iEdge,
  input  logic             iDVAL,
  input  logic             iFVAL,
  input  logic [11:0]      iThreshold,
  output logic [11:0]      oBin,
  output logic             oDVAL,
  output logic [CNT_W-1:0] oEdgeCount,
  output logic [9:0]       oMinX,
  output logic [9:0]       oMaxX,
  output logic [9:0]       oMinY,
  output logic [9:0]       oMaxY,
  output logic             oBoxValid,
  output logic             oFrameDone
);

  localparam logic [9:0]       X_LAST  = 10'(H_ACTIVE - 1);
  localparam logic [9:0]       Y_LAST  = 10'(V_ACTIVE - 1);
  localparam logic [9:0]       BRD     = 10'(BORDER);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // WAIT_LOW swallows any frame already in flight after reset or after a
  // completed frame; a frame is only measured when its rising iFVAL edge is
  // seen from IDLE.
  typedef enum logic [1:0] {WAIT_LOW, IDLE, ACTIVE, DONE} state_e;

  // Running per-frame accumulator.
  typedef struct packed {
    logic [CNT_W-1:0] cnt;
    logic [9:0]       min_x;
    logic [9:0]       max_x;
    logic [9:0]       min_y;
    logic [9:0]       max_y;
  } acc_t;

  state_e      state_q, state_d;
  logic [11:0] thr_q, thr_d;
  logic [9:0]  x_q, x_d;
  logic [9:0]  y_q, y_d;
  acc_t        acc_q, acc_d;

  logic [11:0]      bin_q, bin_d;
  logic             dval_q, dval_d;
  logic [CNT_W-1:0] ocnt_q, ocnt_d;
  logic [9:0]       ominx_q, ominx_d;
  logic [9:0]       omaxx_q, omaxx_d;
  logic [9:0]       ominy_q, ominy_d;
  logic [9:0]       omaxy_q, omaxy_d;
  logic             obv_q, obv_d;
  logic             ofd_q, ofd_d;

  logic frame_start;
  logic px;
  logic is_edge;
  logic last_px;

  // ---------------------------------------------------------------------
  // Per-pixel decode
  // ---------------------------------------------------------------------
  always_comb begin
    frame_start = (state_q == IDLE) && iFVAL;
    px          = (state_q == ACTIVE) && iDVAL;
    // The first BORDER rows/columns are the 3x3 window fill region, where
    // the Sobel output is not meaningful.
    is_edge     = px && (iEdge >= thr_q) && (x_q >= BRD) && (y_q >= BRD);
    last_px     = px && (x_q == X_LAST) && (y_q == Y_LAST);
  end

  // ---------------------------------------------------------------------
  // Frame FSM
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      WAIT_LOW: if (!iFVAL) state_d = IDLE;
      IDLE:     if (iFVAL)  state_d = ACTIVE;
      // A falling iFVAL before the last pixel is a short frame: drop back
      // to IDLE and leave the published statistics untouched.
      ACTIVE: begin
        if (!iFVAL)       state_d = IDLE;
        else if (last_px) state_d = DONE;
      end
      DONE:     state_d = WAIT_LOW;
      default:  state_d = WAIT_LOW;
    endcase
  end

  // ---------------------------------------------------------------------
  // Position counters, shadow threshold and accumulators
  // ---------------------------------------------------------------------
  always_comb begin
    thr_d = thr_q;
    x_d   = x_q;
    y_d   = y_q;
    acc_d = acc_q;
    if (frame_start) begin
      thr_d       = iThreshold;
      x_d         = '0;
      y_d         = '0;
      acc_d.cnt   = '0;
      acc_d.min_x = '1;
      acc_d.max_x = '0;
      acc_d.min_y = '1;
      acc_d.max_y = '0;
    end else if (px) begin
      // y may step one past the last row on the final pixel; it is never
      // used before the next frame start clears it.
      if (x_q == X_LAST) begin
        x_d = '0;
        y_d = y_q + 10'd1;
      end else begin
        x_d = x_q + 10'd1;
      end
      if (is_edge) begin
        if (acc_q.cnt != CNT_MAX) acc_d.cnt = acc_q.cnt + CNT_ONE;
        if (x_q < acc_q.min_x)    acc_d.min_x = x_q;
        if (x_q > acc_q.max_x)    acc_d.max_x = x_q;
        if (y_q < acc_q.min_y)    acc_d.min_y = y_q;
        if (y_q > acc_q.max_y)    acc_d.max_y = y_q;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Output stage
  // ---------------------------------------------------------------------
  always_comb begin
    // oBin holds across iDVAL gaps; valid pixels outside ACTIVE read 0x000
    // because is_edge is already qualified by the state.
    bin_d   = iDVAL ? (is_edge ? 12'hFFF : 12'h000) : bin_q;
    dval_d  = iDVAL;
    ocnt_d  = ocnt_q;
    ominx_d = ominx_q;
    omaxx_d = omaxx_q;
    ominy_d = ominy_q;
    omaxy_d = omaxy_q;
    obv_d   = obv_q;
    ofd_d   = 1'b0;
    if (state_q == DONE) begin
      // Accumulators already include the last pixel (registered on the
      // cycle that moved us into DONE).
      ocnt_d = acc_q.cnt;
      obv_d  = (acc_q.cnt != '0);
      // Count saturates rather than wraps, so non-zero means "saw an edge".
      // An empty frame reports a zero box instead of the all-ones seeds.
      ominx_d = obv_d ? acc_q.min_x : '0;
      omaxx_d = obv_d ? acc_q.max_x : '0;
      ominy_d = obv_d ? acc_q.min_y : '0;
      omaxy_d = obv_d ? acc_q.max_y : '0;
      ofd_d   = 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      state_q <= WAIT_LOW;
      thr_q   <= 12'hFFF;
      x_q     <= '0;
      y_q     <= '0;
      acc_q   <= '0;
      bin_q   <= '0;
      dval_q  <= 1'b0;
      ocnt_q  <= '0;
      ominx_q <= '0;
      omaxx_q <= '0;
      ominy_q <= '0;
      omaxy_q <= '0;
      obv_q   <= 1'b0;
      ofd_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      thr_q   <= thr_d;
      x_q     <= x_d;
      y_q     <= y_d;
      acc_q   <= acc_d;
      bin_q   <= bin_d;
      dval_q  <= dval_d;
      ocnt_q  <= ocnt_d;
      ominx_q <= ominx_d;
      omaxx_q <= omaxx_d;
      ominy_q <= ominy_d;
      omaxy_q <= omaxy_d;
      obv_q   <= obv_d;
      ofd_q   <= ofd_d;
    end
  end

  assign oBin       = bin_q;
  assign oDVAL      = dval_q;
  assign oEdgeCount = ocnt_q;
  assign oMinX      = ominx_q;
  assign oMaxX      = omaxx_q;
  assign oMinY      = ominy_q;
  assign oMaxY      = omaxy_q;
  assign oBoxValid  = obv_q;
  assign oFrameDone = ofd_q;

endmodule

// File: tb/tb_edge_threshold_stats.sv
// Bench for edge_threshold_stats on an 8x6 frame. Two instances share the
// same stimulus: CNT_W=6 (no saturation) and CNT_W=4 (saturates at 15).
// Expected responses are pushed into queues at stimulus time and popped by
// a monitor on the falling edge whenever the DUTs present oDVAL/oFrameDone.
module tb_edge_threshold_stats;
  localparam int H = 8;
  localparam int V = 6;
  localparam int B = 2;

  logic        iCLK = 1'b0;
  logic        iRST;
  logic [11:0] iEdge;
  logic        iDVAL;
  logic        iFVAL;
  logic [11:0] iThreshold;

  logic [11:0] bin6, bin4;
  logic        dv6, dv4;
  logic [5:0]  cnt6;
  logic [3:0]  cnt4;
  logic [9:0]  minx6, maxx6, miny6, maxy6, minx4, maxx4, miny4, maxy4;
  logic        bv6, bv4, fd6, fd4;

  always #5 iCLK = ~iCLK;

  edge_threshold_stats #(.H_ACTIVE(H), .V_ACTIVE(V), .BORDER(B), .CNT_W(6)) u6 (
    .iCLK(iCLK), .iRST(iRST), .iEdge(iEdge), .iDVAL(iDVAL), .iFVAL(iFVAL),
    .iThreshold(iThreshold), .oBin(bin6), .oDVAL(dv6), .oEdgeCount(cnt6),
    .oMinX(minx6), .oMaxX(maxx6), .oMinY(miny6), .oMaxY(maxy6),
    .oBoxValid(bv6), .oFrameDone(fd6));

  edge_threshold_stats #(.H_ACTIVE(H), .V_ACTIVE(V), .BORDER(B), .CNT_W(4)) u4 (
    .iCLK(iCLK), .iRST(iRST), .iEdge(iEdge), .iDVAL(iDVAL), .iFVAL(iFVAL),
    .iThreshold(iThreshold), .oBin(bin4), .oDVAL(dv4), .oEdgeCount(cnt4),
    .oMinX(minx4), .oMaxX(maxx4), .oMinY(miny4), .oMaxY(maxy4),
    .oBoxValid(bv4), .oFrameDone(fd4));

  typedef struct {
    int cnt6;
    int cnt4;
    int minx;
    int maxx;
    int miny;
    int maxy;
    int bv;
  } stats_t;

  logic [11:0] img [V][H];
  logic [11:0] binq [$];
  stats_t      stq [$];
  stats_t      last_st;
  logic [11:0] last_bin;
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  task automatic cmp_stats(input string nm, input stats_t e);
    chk($sformatf("%s.count", nm),    int'(cnt6),  e.cnt6);
    chk($sformatf("%s.count_w4", nm), int'(cnt4),  e.cnt4);
    chk($sformatf("%s.minx", nm),     int'(minx6), e.minx);
    chk($sformatf("%s.maxx", nm),     int'(maxx6), e.maxx);
    chk($sformatf("%s.miny", nm),     int'(miny6), e.miny);
    chk($sformatf("%s.maxy", nm),     int'(maxy6), e.maxy);
    chk($sformatf("%s.boxvalid", nm), int'(bv6),   e.bv);
    chk($sformatf("%s.box_w4", nm),
        int'({minx4, maxx4, miny4, maxy4, bv4}),
        (e.minx << 31) | (e.maxx << 21) | (e.miny << 11) | (e.maxy << 1) | e.bv);
  endtask

  // Reference: count every pixel meeting the threshold outside the border,
  // then derive saturated counts and the bounding box from the edge set.
  function automatic stats_t model(input logic [11:0] thr);
    stats_t s;
    int n = 0;
    int mnx = 1000, mxx = -1, mny = 1000, mxy = -1;
    for (int y = 0; y < V; y++)
      for (int x = 0; x < H; x++)
        if (img[y][x] >= thr && x >= B && y >= B) begin
          n++;
          if (x < mnx) mnx = x;
          if (x > mxx) mxx = x;
          if (y < mny) mny = y;
          if (y > mxy) mxy = y;
        end
    s.cnt6 = (n > 63) ? 63 : n;
    s.cnt4 = (n > 15) ? 15 : n;
    s.bv   = (n > 0) ? 1 : 0;
    s.minx = (n > 0) ? mnx : 0;
    s.maxx = (n > 0) ? mxx : 0;
    s.miny = (n > 0) ? mny : 0;
    s.maxy = (n > 0) ? mxy : 0;
    return s;
  endfunction

  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  task automatic fill(input logic [11:0] v);
    for (int y = 0; y < V; y++)
      for (int x = 0; x < H; x++)
        img[y][x] = v;
  endtask

  // Asynchronous reset pulse; all outputs of both instances must read zero.
  task automatic do_reset();
    stats_t z;
    z = '{default: 0};
    iRST = 1'b0;
    #1;
    binq.delete();
    stq.delete();
    last_bin = '0;
    last_st  = z;
    chk("reset.oBin",       int'(bin6), 0);
    chk("reset.oBin_w4",    int'(bin4), 0);
    chk("reset.oDVAL",      int'(dv6 | dv4), 0);
    chk("reset.oFrameDone", int'(fd6 | fd4), 0);
    cmp_stats("reset", z);
    tick();
    iRST = 1'b1;
  endtask

  // Drive one frame. stop_at >= 0 interrupts it after that many pixels:
  // either by dropping iFVAL (short frame) or by a reset with iFVAL held.
  task automatic run_frame(input logic [11:0] thr, input logic [11:0] thr_mid,
                           input int stop_at, input bit rst_at_stop, input int gap_pct);
    stats_t s;
    bit processed = 1'b1;
    bit aborted   = 1'b0;
    s = model(thr);
    iThreshold = thr;
    iFVAL = 1'b1;
    iDVAL = 1'b0;
    tick();
    for (int k = 0; k < H * V; k++) begin
      int x = k % H;
      int y = k / H;
      if (k == stop_at) begin
        iDVAL = 1'b0;
        tick();
        tick();
        if (!rst_at_stop) begin
          aborted = 1'b1;
          break;
        end
        do_reset();
        processed = 1'b0;
      end
      for (int g = 0; g < 3 && $urandom_range(99) < gap_pct; g++) begin
        iDVAL = 1'b0;
        iEdge = 12'($urandom);
        tick();
      end
      iEdge = img[y][x];
      iDVAL = 1'b1;
      binq.push_back((processed && img[y][x] >= thr && x >= B && y >= B) ? 12'hFFF : 12'h000);
      tick();
      if (k == 0) iThreshold = thr_mid;
    end
    iDVAL = 1'b0;
    if (aborted) begin
      iFVAL = 1'b0;
      repeat (3) tick();
      cmp_stats("abort_hold", last_st);
    end else begin
      if (processed) begin
        stq.push_back(s);
        last_st = s;
      end
      tick();
      tick();
      iFVAL = 1'b0;
      repeat (3) tick();
    end
  endtask

  // Monitor: compares whatever the DUTs present against the queues.
  always @(negedge iCLK) begin
    if (iRST === 1'b1) begin
      if (dv6 || dv4) begin
        if (binq.size() == 0) begin
          chk("oDVAL_unexpected", 1, 0);
        end else begin
          logic [11:0] e;
          e = binq.pop_front();
          chk("oBin", int'(bin6), int'(e));
          chk("oBin_w4", int'(bin4), int'(e));
          chk("oDVAL_w4", int'(dv4), 1);
          last_bin = e;
        end
      end else begin
        chk("oBin_hold", int'(bin6), int'(last_bin));
      end
      if (fd6 || fd4) begin
        if (stq.size() == 0) begin
          chk("oFrameDone_unexpected", 1, 0);
        end else begin
          stats_t s;
          s = stq.pop_front();
          chk("oFrameDone_w4", int'(fd4 & fd6), 1);
          cmp_stats("frame", s);
        end
      end
    end
  end

  initial begin
    iRST = 1'b1;
    iEdge = '0;
    iDVAL = 1'b0;
    iFVAL = 1'b0;
    iThreshold = '0;
    last_bin = '0;
    last_st = '{default: 0};
    #2;
    do_reset();
    repeat (3) tick();

    // Full uniform frame at threshold: 24 edges, box (2,7,2,5), 15 at CNT_W=4.
    fill(12'h100);
    run_frame(12'h100, 12'h100, -1, 1'b0, 0);

    // Single edge pixel inside the active region.
    fill(12'h000);
    img[3][5] = 12'h800;
    run_frame(12'h400, 12'h400, -1, 1'b0, 0);

    // Short frame: outputs must keep the single-pixel result.
    fill(12'h100);
    run_frame(12'h100, 12'h100, 20, 1'b0, 0);
    run_frame(12'h100, 12'h100, -1, 1'b0, 0);

    // Single edge pixel in the masked border column.
    fill(12'h000);
    img[3][1] = 12'h800;
    run_frame(12'h400, 12'h400, -1, 1'b0, 0);

    // Threshold changed mid-frame has no effect until the next frame.
    fill(12'h100);
    run_frame(12'h200, 12'h050, -1, 1'b0, 0);
    run_frame(12'h050, 12'h050, -1, 1'b0, 0);

    // Reset mid-frame with iFVAL held: that frame is ignored, next reports.
    run_frame(12'h100, 12'h100, 17, 1'b1, 0);
    run_frame(12'h100, 12'h100, -1, 1'b0, 0);

    // Same all-edge frame with blanking gaps: identical statistics.
    run_frame(12'h100, 12'h100, -1, 1'b0, 50);

    // Randomized frames and thresholds with gaps.
    for (int f = 0; f < 4; f++) begin
      logic [11:0] thr;
      thr = 12'($urandom_range(12'h200, 12'hE00));
      for (int y = 0; y < V; y++)
        for (int x = 0; x < H; x++)
          img[y][x] = 12'($urandom_range(0, 12'hFFF));
      run_frame(thr, 12'($urandom), -1, 1'b0, 25);
    end

    repeat (4) tick();
    chk("bin_queue_drained", binq.size(), 0);
    chk("stats_queue_drained", stq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/edge_threshold_stats.md
Name: edge_threshold_stats

Overview:
- Downstream consumer of the Sobel edge-magnitude stage. Takes the 12-bit edge stream and the per-pixel valid, and produces a registered binary edge map, pre-scaled 0x000 or 0xFFF for the VGA/SDRAM write path.
- Accumulates per-frame statistics: edge-pixel count and bounding box of the edge pixels. Latches them at end of frame for the object-tracking logic.
- Masks the window-fill border, where the 3x3 convolution output is invalid.

Parameters:
- H_ACTIVE, 640, valid pixels per line.
- V_ACTIVE, 480, valid lines per frame.
- BORDER, 2, number of leading columns and leading rows forced to non-edge.
- CNT_W, 20, width of the edge-count accumulator (saturating).

Ports:
- iCLK  in  1  pixel clock.
- iRST  in  1  asynchronous active-low reset.
- iEdge  in  12  edge magnitude from the Sobel stage.
- iDVAL  in  1  iEdge valid this cycle.
- iFVAL  in  1  frame valid; high across the active frame.
- iThreshold  in  12  edge threshold. Sampled into a shadow register on frame start.
- oBin  out  12  0xFFF if edge pixel, else 0x000.
- oDVAL  out  1  oBin valid (iDVAL delayed 1 cycle).
- oEdgeCount  out  CNT_W  edge pixels in the last completed frame.
- oMinX, oMaxX  out  10  bounding-box columns, last completed frame.
- oMinY, oMaxY  out  10  bounding-box rows, last completed frame.
- oBoxValid  out  1  last completed frame had at least one edge pixel.
- oFrameDone  out  1  single-cycle pulse when the statistics outputs update.

Behaviour:
- Reset (iRST low, asynchronous):
  - All outputs go to 0.
  - Counters and accumulators clear.
  - Shadow threshold goes to 0xFFF.
  - FSM enters WAIT_LOW.
- FSM transitions:
  - WAIT_LOW -> IDLE when iFVAL==0. This guarantees a frame that was in progress at reset is ignored.
  - IDLE -> ACTIVE on iFVAL==1. On that same cycle: capture iThreshold into the shadow register, x=0, y=0, clear accumulators (count=0, min=all-ones, max=0).
  - ACTIVE: each cycle with iDVAL=1 processes one pixel at (x,y). x increments; at x==H_ACTIVE-1, x wraps to 0 and y increments.
  - ACTIVE -> DONE when the pixel at (H_ACTIVE-1, V_ACTIVE-1) is processed with iDVAL=1.
  - ACTIVE -> IDLE if iFVAL falls before the last pixel (short frame). Abort: accumulators discarded, statistics outputs unchanged, no oFrameDone.
  - DONE: one cycle. Latch count/min/max/box-valid to outputs, pulse oFrameDone=1, then go to WAIT_LOW.
- Pixels arriving with iDVAL=1 while in DONE or WAIT_LOW are ignored for statistics. They still pass through the oBin path.
- Edge decision per pixel: edge = (iEdge >= shadow threshold) && (x >= BORDER) && (y >= BORDER) && state==ACTIVE. Comparison is unsigned 12-bit.
- oBin/oDVAL latency:
  - 1 cycle: oBin <= edge ? 0xFFF : 0x000; oDVAL <= iDVAL.
  - When iDVAL=0, oBin holds its previous value.
  - Outside ACTIVE, oBin=0x000 for valid pixels.
- Count: increments on each edge pixel and saturates at 2^CNT_W-1. It does not wrap.
- Bounding box: on each edge pixel, minX=min(minX,x), maxX=max(maxX,x), minY=min(minY,y), maxY=max(maxY,y).
- Statistics update is simultaneous: if the last pixel is an edge, it is included in the latched values.
- Zero-edge frame: oBoxValid=0 and oMinX/oMaxX/oMinY/oMaxY=0. oEdgeCount=0 and oFrameDone still pulses.
- A change on iThreshold mid-frame has no effect until the next IDLE->ACTIVE.
- iDVAL gaps (blanking) are allowed anywhere. Counters advance only on iDVAL=1.
- Reset mid-frame: immediate clear, and no statistics are produced for that frame.

Test Plan (bench uses H_ACTIVE=8, V_ACTIVE=6, BORDER=2, CNT_W=6):
- Reset, then a full frame of iEdge=0x100 with iThreshold=0x100 -> oBin=0xFFF for pixels with x>=2,y>=2 and 0x000 elsewhere, each 1 cycle after input. oFrameDone pulses once; oEdgeCount=24; box=(2,7,2,5); oBoxValid=1.
- Single pixel iEdge=0x800 at (5,3), all others 0, threshold 0x400 -> count=1, minX=maxX=5, minY=maxY=3. The same stimulus at (1,3) -> count=0, oBoxValid=0, box outputs 0.
- Set threshold 0x200 before the frame; change it to 0x050 mid-frame with iEdge=0x100 everywhere -> no edges, count=0. Next frame -> count=24.
- Drop iFVAL after 20 pixels of an all-edge frame -> no oFrameDone; outputs keep the prior frame values. The following full frame reports correctly.
- Assert iRST mid-frame with iFVAL held high, release, then complete the frame -> no oFrameDone for that frame. The next frame (iFVAL low then high) reports count=24.
- With CNT_W=4, an all-edge frame -> oEdgeCount=15 (saturated). Random iDVAL gaps in the same frame -> identical statistics.
